// File: rtl/systolic_skew_feeder_if.sv
// rtl/systolic_skew_feeder_if.sv - upstream vector handshake into the skew feeder
interface systolic_skew_feeder_if #(
    parameter int ROWS   = 4,
    parameter int DATA_W = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic [ROWS*DATA_W-1:0]   in_data;
    logic                     in_last;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - re-times column vectors into the diagonal wavefront for the PE array
module systolic_skew_feeder #(
    parameter int ROWS   = 4,
    parameter int DATA_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    systolic_skew_feeder_if.slave  up,
    output logic [ROWS*DATA_W-1:0] out_data,
    output logic [ROWS-1:0]        out_valid,
    output logic                   busy,
    output logic                   done
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FEED  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam int             CW       = $clog2(ROWS) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(ROWS - 1);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nx;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nx;
    logic          r_done;
    logic          w_ready;
    logic          w_fire;

    assign w_ready     = (r_state != S_DRAIN);
    assign up.in_ready = w_ready;
    assign w_fire      = up.in_valid && w_ready;

    // Lane i is i+1 registers deep; a non-accepting edge injects a zero bubble at every head.
    for (genvar i = 0; i < ROWS; i++) begin : g_lane
        logic [i:0]        r_v;
        logic [DATA_W-1:0] r_d [0:i];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_v <= '0;
                for (int k = 0; k <= i; k++) begin
                    r_d[k] <= '0;
                end
            end else begin
                r_v[0] <= w_fire;
                r_d[0] <= w_fire ? up.in_data[i*DATA_W +: DATA_W] : '0;
                for (int k = 1; k <= i; k++) begin
                    r_v[k] <= r_v[k-1];
                    r_d[k] <= r_d[k-1];
                end
            end
        end

        assign out_valid[i]                 = r_v[i];
        assign out_data[i*DATA_W +: DATA_W] = r_d[i];
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        case (r_state)
            S_IDLE, S_FEED: begin
                if (w_fire) begin
                    if (up.in_last) begin
                        w_state_nx = S_DRAIN;
                        w_cnt_nx   = '0;
                    end else begin
                        w_state_nx = S_FEED;
                    end
                end
            end
            S_DRAIN: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // done is registered from the next-state view so it lines up with the final lane's output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_done  <= (w_state_nx == S_DRAIN) && (w_cnt_nx == CNT_LAST);
        end
    end

    assign done = r_done;
    assign busy = (r_state != S_IDLE) || (|out_valid);
endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Upstream stage of the systolic array. Accepts one column vector of ROWS signed image values per handshake.
- Re-times the vector into the diagonal wavefront the PE grid needs: the lane i element reaches array row i exactly i cycles after the lane 0 element.
- Drives the matriz_value inputs of the left-edge PEs. Invalid slots are forced to zero, so bubbles contribute nothing to any partial_result.

Parameters:
- ROWS, 4, number of array rows / lanes (>=1)
- DATA_W, 16, signed element width (matches PE datapath)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset: one clock; synchronous, active-low
- in_valid  in  1  upstream vector valid
- in_ready  out  1  feeder can accept a vector this cycle
- in_data  in  ROWS*DATA_W  lane i in bits [i*DATA_W +: DATA_W], signed
- in_last  in  1  marks final vector of the current tile; qualified by handshake
- out_data  out  ROWS*DATA_W  skewed lane values to array row i, same packing
- out_valid  out  ROWS  per-lane valid
- busy  out  1  state != IDLE or any out_valid bit set
- done  out  1  one-cycle pulse when the last vector's lane ROWS-1 element is on out_data

Behaviour:
- Handshake: a vector is accepted at a rising edge where in_valid && in_ready. When in_ready=0, in_valid, in_data and in_last are ignored and nothing is consumed. The array side has no backpressure; the feeder advances every cycle.
- Datapath: lane i is a shift chain of depth i+1 holding {valid, data}.
  - A vector accepted at edge E0 appears on lane i after edge E0+i, i.e. latency i+1 cycles.
  - Data passes bit-exact; there is no arithmetic or sign change.
- Bubbles: on any edge with no handshake, a {0, 0} bubble enters every lane head.
  - When out_valid[i]=0, out_data lane i must be 0.
  - Gaps between vectors are preserved exactly in every lane.
- State machine, with counter cnt of width clog2(ROWS)+1:
  - IDLE: in_ready=1. A handshake with in_last=0 goes to FEED. A handshake with in_last=1 goes to DRAIN with cnt=0.
  - FEED: in_ready=1. A handshake with in_last=1 goes to DRAIN with cnt=0. Otherwise stay in FEED.
  - DRAIN: in_ready=0; cnt increments each edge. When cnt==ROWS-1, done is asserted this cycle and the next state is IDLE.
  - Net timing: last vector accepted at E0 → done high only in the cycle following E0+ROWS-1, together with out_valid[ROWS-1] of that vector → in_ready high again after edge E0+ROWS.
  - ROWS=1: DRAIN lasts one cycle; done coincides with the lane 0 output.
- done is registered and lasts exactly one cycle. A new tile cannot start before done, because in_ready=0 throughout DRAIN.
- Reset values (rst_n=0 at an edge): all lane registers {0,0}, out_data=0, out_valid=0, state=IDLE, cnt=0, done=0, in_ready=1 (after reset), busy=0.
- Reset mid-operation discards all in-flight elements; no done is produced for the aborted tile.

Test Plan:
- ROWS=4, single vector {lane0..3 = 1, -2, 3, -4} with in_last=1 at E0:
  - out_valid = 0001, 0010, 0100, 1000 in successive cycles after E0..E3, with lane values 1, -2, 3, -4.
  - done high only after E3; in_ready low after E0..E3, high after E4.
- Back-to-back stream of vectors V0..V5 (V_k lane i = 10k+i), in_last on V5:
  - Lane i shows V0..V5 contiguously starting after edge E0+i.
  - in_ready stays 1 until V5 is accepted; done comes 4 cycles after V5 is accepted.
- Gap insertion: V0, one idle cycle, V1:
  - Each lane shows V0, a zero bubble (valid 0, data 0), then V1, with the same spacing in all lanes.
- Backpressure: hold in_valid=1 with new data during DRAIN:
  - No acceptance and no change to the output sequence.
  - The held vector is accepted in the first cycle in_ready=1 and emerges on lane 0 one cycle later.
- Reset mid-drain: pull rst_n=0 after E1 of a last vector:
  - Next cycle: all out_valid=0, out_data=0, busy=0, in_ready=1.
  - done never pulses for that tile.
- Extremes: lane values 0x7FFF and 0x8000 pass unchanged; ROWS=1 build gives done together with out_valid[0] one cycle after accept.
